// File: rtl/modulus_lut_pkg.sv
// Shared constants, header field layout and FSM encoding for the modulus LUT loader.
package modulus_lut_pkg;

    localparam int MODULUS_WIDTH = 1024;
    localparam int IN_WIDTH      = 64;
    localparam int BEATS         = MODULUS_WIDTH / IN_WIDTH;
    localparam int BEAT_BITS     = $clog2(BEATS);
    localparam int NUM_CHUNKS    = 22;
    localparam int LUT_ADDR_BITS = 9;
    localparam int CHUNK_BITS    = 5;
    localparam int TERM_BITS     = 4;

    localparam int HDR_CHUNK_LSB = 0;
    localparam int HDR_TERM_LSB  = 8;
    localparam int HDR_ADDR_LSB  = 16;
    localparam int HDR_COUNT_LSB = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DISCARD
    } load_state_e;

    // Number of terms stored per chunk; out-of-range chunks report zero so
    // every term index fails against them.
    function automatic logic [TERM_BITS-1:0] terms_in_chunk(input logic [CHUNK_BITS-1:0] chunk);
        if (chunk == 5'd0)
            return 4'd6;
        else if (chunk <= 5'd8)
            return 4'd10;
        else if (chunk <= 5'd20)
            return 4'd7;
        else if (chunk == 5'd21)
            return 4'd3;
        else
            return 4'd0;
    endfunction

endpackage

// File: rtl/lut_term_assembler.sv
// Collects BEATS little-endian input beats into one MODULUS_WIDTH term.
// The first BEATS-1 beats are stored; the final beat is forwarded straight through.
module lut_term_assembler
    import modulus_lut_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     beat_valid,
    input  logic [IN_WIDTH-1:0]      beat_in,
    output logic                     term_done,
    output logic [MODULUS_WIDTH-1:0] term_data
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    logic [BEAT_BITS-1:0]              beat_cnt;
    logic [BEATS-2:0][IN_WIDTH-1:0]    fill_q;

    assign term_done = beat_valid && (beat_cnt == LAST_BEAT);
    assign term_data = {beat_in, fill_q};

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear)
            beat_cnt <= '0;
        else if (beat_valid)
            beat_cnt <= term_done ? '0 : beat_cnt + 1'b1;
    end

    // NOTE: the fill storage is deliberately not reset; its contents are only
    // observed after a full entry has been rewritten, so a reset would just
    // add fan-out on a very wide bus.
    always_ff @(posedge clk) begin
        if (beat_valid && !term_done)
            fill_q[beat_cnt] <= beat_in;
    end

endmodule

// File: rtl/modulus_lut_loader.sv
// Header-validated loader that turns a beat stream into one wide LUT write per entry.
// Owns the framing FSM, header checks, address counter and registered write port.
module modulus_lut_loader
    import modulus_lut_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [IN_WIDTH-1:0]      s_data,
    input  logic                     s_last,
    output logic                     wr_valid,
    output logic [CHUNK_BITS-1:0]    wr_chunk,
    output logic [TERM_BITS-1:0]     wr_term,
    output logic [LUT_ADDR_BITS-1:0] wr_addr,
    output logic [MODULUS_WIDTH-1:0] wr_data,
    output logic                     busy,
    output logic                     load_done,
    output logic                     err
);

    load_state_e state_q, state_d;

    logic ready_q;
    logic accept;

    logic [CHUNK_BITS-1:0]    hdr_chunk;
    logic [TERM_BITS-1:0]     hdr_term;
    logic [LUT_ADDR_BITS-1:0] hdr_addr;
    logic [LUT_ADDR_BITS-1:0] hdr_count_m1;
    logic [LUT_ADDR_BITS:0]   hdr_end;
    logic                     hdr_ok;

    logic [CHUNK_BITS-1:0]    chunk_q;
    logic [TERM_BITS-1:0]     term_q;
    logic [LUT_ADDR_BITS-1:0] addr_q;
    logic [LUT_ADDR_BITS-1:0] left_q;

    logic hdr_start;
    logic write_fire;
    logic done_fire;
    logic err_set;

    logic                     asm_beat_valid;
    logic                     term_done;
    logic [MODULUS_WIDTH-1:0] term_data;

    assign s_ready = ready_q;
    assign accept  = s_valid && ready_q;
    assign busy    = (state_q != ST_IDLE);

    assign hdr_chunk    = s_data[HDR_CHUNK_LSB +: CHUNK_BITS];
    assign hdr_term     = s_data[HDR_TERM_LSB  +: TERM_BITS];
    assign hdr_addr     = s_data[HDR_ADDR_LSB  +: LUT_ADDR_BITS];
    assign hdr_count_m1 = s_data[HDR_COUNT_LSB +: LUT_ADDR_BITS];

    // Carry out of the last-entry address means the load would wrap the table.
    assign hdr_end = {1'b0, hdr_addr} + {1'b0, hdr_count_m1};
    assign hdr_ok  = (hdr_chunk < CHUNK_BITS'(NUM_CHUNKS))
                  && (hdr_term < terms_in_chunk(hdr_chunk))
                  && !hdr_end[LUT_ADDR_BITS];

    assign asm_beat_valid = accept && (state_q == ST_DATA);

    lut_term_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (hdr_start),
        .beat_valid (asm_beat_valid),
        .beat_in    (s_data),
        .term_done  (term_done),
        .term_data  (term_data)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hdr_start  = 1'b0;
        write_fire = 1'b0;
        done_fire  = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_last) begin
                        err_set = 1'b1;
                    end else if (hdr_ok) begin
                        state_d   = ST_DATA;
                        hdr_start = 1'b1;
                    end else begin
                        state_d = ST_DISCARD;
                        err_set = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    write_fire = term_done;
                    if (s_last) begin
                        state_d = ST_IDLE;
                        if (term_done && left_q == '0)
                            done_fire = 1'b1;
                        else
                            err_set = 1'b1;
                    end else if (term_done && left_q == '0) begin
                        // Packet ran past its declared length: keep what was written, drop the rest.
                        state_d = ST_DISCARD;
                        err_set = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (accept && s_last)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            err       <= 1'b0;
            wr_valid  <= 1'b0;
            load_done <= 1'b0;
            wr_chunk  <= '0;
            wr_term   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            chunk_q   <= '0;
            term_q    <= '0;
            addr_q    <= '0;
            left_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= 1'b1;
            err       <= err | err_set;
            wr_valid  <= write_fire;
            load_done <= done_fire;
            if (hdr_start) begin
                chunk_q <= hdr_chunk;
                term_q  <= hdr_term;
                addr_q  <= hdr_addr;
                left_q  <= hdr_count_m1;
            end else if (write_fire) begin
                addr_q <= addr_q + 1'b1;
                left_q <= left_q - 1'b1;
            end
            if (write_fire) begin
                wr_chunk <= chunk_q;
                wr_term  <= term_q;
                wr_addr  <= addr_q;
                wr_data  <= term_data;
            end
        end
    end

endmodule
